// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encodings
// and the default operand width.
package serial_subtractor_pkg;

    localparam int SUB_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_full_sub.sv
// Single-bit full subtractor cell: difference and borrow-out of a - b - bin.
module full_sub (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor computing A - B - Bin LSB-first,
// one bit per clock through a single full_sub cell.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bout
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t             state;
    state_t             next_state;
    logic [WIDTH-1:0]   sa;
    logic [WIDTH-1:0]   sb;
    logic [WIDTH-1:0]   result;
    logic [CNT_W-1:0]   cnt;
    logic               br;
    logic               d_bit;
    logic               bout_bit;
    logic               last_bit;

    full_sub u_full_sub (
        .a    (sa[0]),
        .b    (sb[0]),
        .bin  (br),
        .d    (d_bit),
        .bout (bout_bit)
    );

    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    // busy and done decode directly from the state register, so they
    // stay free of any combinational path from the inputs.
    assign busy = (state == ST_SHIFT);
    assign done = (state == ST_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (start) next_state = ST_SHIFT;
            ST_SHIFT: if (last_bit) next_state = ST_DONE;
            ST_DONE:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Operands shift right so the full_sub cell always sees the current bit
    // at position 0; the difference fills the result register from the top.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa     <= '0;
            sb     <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            result <= '0;
            D      <= '0;
            Bout   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        sa     <= A;
                        sb     <= B;
                        br     <= Bin;
                        cnt    <= '0;
                        result <= '0;
                    end
                end
                ST_SHIFT: begin
                    sa     <= sa >> 1;
                    sb     <= sb >> 1;
                    br     <= bout_bit;
                    cnt    <= cnt + CNT_W'(1);
                    result <= {d_bit, result[WIDTH-1:1]};
                    if (last_bit) begin
                        D    <= {d_bit, result[WIDTH-1:1]};
                        Bout <= bout_bit;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
